// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares the UART TX FIFO write port between NUM_REQ byte streams.
// A grant is held for a whole burst; it is released on the last beat, at MAX_BURST beats, or after TIMEOUT idle cycles.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        fifo_full,
    output logic                        fifo_wr,
    output logic [DATA_W-1:0]           fifo_wr_data,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        busy,
    output logic                        abort
);

    localparam int unsigned IDW = $clog2(NUM_REQ);
    localparam int unsigned BCW = $clog2(MAX_BURST) + 1;
    localparam int unsigned ICW = $clog2(TIMEOUT) + 1;

    typedef enum logic {IDLE, XFER} state_e;

    state_e          state_q, state_d;
    logic [IDW-1:0]  grant_id_q, grant_id_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [BCW-1:0]  beat_cnt_q, beat_cnt_d;
    logic [ICW-1:0]  idle_cnt_q, idle_cnt_d;

    logic [IDW-1:0]     pick;
    logic [IDW-1:0]     g_next;
    logic               g_valid;
    logic               g_last;
    logic [DATA_W-1:0]  g_data;
    logic [NUM_REQ-1:0] g_sel;
    logic               accept;
    logic               timeout;
    logic               burst_done;

    // Circular index (base + off) mod NUM_REQ; safe for non-power-of-2 NUM_REQ.
    function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int off);
        int unsigned s;
        s = 32'(base) + 32'(off);
        return IDW'(s % NUM_REQ);
    endfunction

    // First valid requester at or after rr_ptr; the lowest offset wins.
    always_comb begin
        pick = rr_ptr_q;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[rr_idx(rr_ptr_q, k)]) begin
                pick = rr_idx(rr_ptr_q, k);
            end
        end
    end

    // Mux the granted requester's signals.
    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        g_sel   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id_q == IDW'(i)) begin
                g_valid  = req_valid[i];
                g_last   = req_last[i];
                g_data   = req_data[i*DATA_W +: DATA_W];
                g_sel[i] = 1'b1;
            end
        end
    end

    assign g_next     = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + IDW'(1);
    assign accept     = (state_q == XFER) & g_valid & ~fifo_full;
    assign timeout    = (state_q == XFER) & ~g_valid & (idle_cnt_q == ICW'(TIMEOUT - 1));
    assign burst_done = accept & (g_last | (beat_cnt_q == BCW'(MAX_BURST - 1)));

    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        rr_ptr_d     = rr_ptr_q;
        beat_cnt_d   = beat_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        req_ready    = '0;
        fifo_wr      = 1'b0;
        fifo_wr_data = '0;
        busy         = 1'b0;
        abort        = 1'b0;

        case (state_q)
            IDLE: begin
                beat_cnt_d = '0;
                idle_cnt_d = '0;
                if (|req_valid) begin
                    grant_id_d = pick;
                    state_d    = XFER;
                end
            end
            XFER: begin
                busy         = 1'b1;
                req_ready    = fifo_full ? '0 : g_sel;
                fifo_wr      = accept;
                fifo_wr_data = g_data;
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + BCW'(1);
                end
                // Stalls on a full FIFO with valid high are not idle time.
                idle_cnt_d = g_valid ? '0 : idle_cnt_q + ICW'(1);
                if (burst_done || timeout) begin
                    state_d  = IDLE;
                    rr_ptr_d = g_next;
                    abort    = timeout;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench for uart_tx_arbiter against a transaction-level arbitration model.
// Each requester owns a byte queue; the model decides ownership and acceptance, and a monitor compares every cycle.
module tb_uart_tx_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned DW  = 8;
    localparam int unsigned MB  = 16;
    localparam int unsigned TO  = 64;
    localparam int unsigned IDW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_last;
    logic [N-1:0]      req_ready;
    logic              fifo_full;
    logic              fifo_wr;
    logic [DW-1:0]     fifo_wr_data;
    logic [IDW-1:0]    grant_id;
    logic              busy;
    logic              abort;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ  (N),
        .DATA_W   (DW),
        .MAX_BURST(MB),
        .TIMEOUT  (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .fifo_full   (fifo_full),
        .fifo_wr     (fifo_wr),
        .fifo_wr_data(fifo_wr_data),
        .grant_id    (grant_id),
        .busy        (busy),
        .abort       (abort)
    );

    typedef struct packed {
        logic [N-1:0]   ready;
        logic           wr;
        logic [DW-1:0]  data;
        logic [IDW-1:0] gid;
        logic           busy;
        logic           abort;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    // Requester-side byte streams: {last, data} per entry.
    logic [DW:0] pend[N][$];
    bit          hold[N];
    bit          mute[N];
    int          gap_pct;
    int          full_pct;
    bit          full_force;

    // Model: who owns the write port, where the round robin resumes,
    // bytes sent in the current grant and consecutive silent cycles.
    int m_owner;
    int m_ptr;
    int m_gid;
    int m_sent;
    int m_quiet;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_gid   = 0;
        m_sent  = 0;
        m_quiet = 0;
    endtask

    task automatic add_burst(input int r, input int len);
        logic [DW-1:0] d;
        for (int i = 0; i < len; i++) begin
            d = DW'($urandom);
            pend[r].push_back({(i == len - 1), d});
        end
    endtask

    task automatic model_step(output logic [N-1:0] acc);
        exp_t e;
        int   o;
        e     = '0;
        acc   = '0;
        e.gid = IDW'(m_gid);
        if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                if (m_owner < 0 && req_valid[(m_ptr + k) % N]) begin
                    m_owner = (m_ptr + k) % N;
                    m_gid   = m_owner;
                    m_sent  = 0;
                    m_quiet = 0;
                end
            end
        end else begin
            o      = m_owner;
            e.busy = 1'b1;
            e.data = req_data[o*DW +: DW];
            if (!fifo_full) e.ready[o] = 1'b1;
            if (req_valid[o]) m_quiet = 0;
            else              m_quiet++;
            if (req_valid[o] && !fifo_full) begin
                e.wr   = 1'b1;
                acc[o] = 1'b1;
                m_sent++;
                if (req_last[o] || m_sent == MB) begin
                    m_owner = -1;
                    m_ptr   = (o + 1) % N;
                end
            end else if (m_quiet == TO) begin
                e.abort = 1'b1;
                m_owner = -1;
                m_ptr   = (o + 1) % N;
            end
        end
        exp_q.push_back(e);
    endtask

    // Drive one cycle of requester/FIFO stimulus, predict, advance one clock.
    task automatic step();
        logic [N-1:0] acc;
        logic [DW:0]  b;
        for (int r = 0; r < N; r++) begin
            if (pend[r].size() != 0 && !mute[r] &&
                (hold[r] || $urandom_range(0, 99) >= gap_pct)) begin
                b                     = pend[r][0];
                req_valid[r]          = 1'b1;
                req_last[r]           = b[DW];
                req_data[r*DW +: DW]  = b[DW-1:0];
                hold[r]               = 1'b1;
            end else begin
                req_valid[r]          = 1'b0;
                req_last[r]           = 1'($urandom);
                req_data[r*DW +: DW]  = DW'($urandom);
            end
        end
        fifo_full = full_force || ($urandom_range(0, 99) < full_pct);
        model_step(acc);
        for (int r = 0; r < N; r++) begin
            if (acc[r]) begin
                void'(pend[r].pop_front());
                hold[r] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  64'(busy),         64'(0));
        check({tag, "_wr"},    64'(fifo_wr),      64'(0));
        check({tag, "_ready"}, 64'(req_ready),    64'(0));
        check({tag, "_gid"},   64'(grant_id),     64'(0));
        check({tag, "_abort"}, 64'(abort),        64'(0));
        check({tag, "_data"},  64'(fifo_wr_data), 64'(0));
    endtask

    // Monitor: compare the DUT against the oldest prediction each cycle.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("busy",      64'(busy),         64'(mon_e.busy));
            check("abort",     64'(abort),        64'(mon_e.abort));
            check("fifo_wr",   64'(fifo_wr),      64'(mon_e.wr));
            check("req_ready", 64'(req_ready),    64'(mon_e.ready));
            check("grant_id",  64'(grant_id),     64'(mon_e.gid));
            check("wr_data",   64'(fifo_wr_data), 64'(mon_e.data));
        end
    end

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        req_last   = '0;
        req_data   = '0;
        fifo_full  = 1'b0;
        full_force = 1'b0;
        gap_pct    = 0;
        full_pct   = 0;
        for (int r = 0; r < N; r++) begin
            hold[r] = 1'b0;
            mute[r] = 1'b0;
        end
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst_idle");
        req_valid = '1;
        @(posedge clk);
        #1;
        check_reset_outputs("rst_held");
        req_valid = '0;
        rst       = 1'b0;

        // Single requester, three-byte burst.
        add_burst(2, 3);
        repeat (6) step();

        // Everyone with two-byte bursts.
        for (int r = 0; r < N; r++) add_burst(r, 2);
        repeat (16) step();

        // Long stream split by MAX_BURST, plus a burst ending exactly at the limit.
        add_burst(1, 20);
        add_burst(0, 2);
        add_burst(3, 1);
        add_burst(2, 16);
        repeat (80) step();

        // FIFO full for ten cycles mid-burst.
        add_burst(3, 8);
        repeat (3) step();
        full_force = 1'b1;
        repeat (10) step();
        full_force = 1'b0;
        repeat (10) step();

        // Granted requester goes silent long enough to time out.
        add_burst(0, 2);
        repeat (2) step();
        mute[0] = 1'b1;
        hold[0] = 1'b0;
        repeat (66) step();
        mute[0] = 1'b0;
        add_burst(1, 1);
        repeat (10) step();

        // Random traffic with gaps and FIFO back-pressure.
        gap_pct  = 25;
        full_pct = 20;
        for (int c = 0; c < 1500; c++) begin
            for (int r = 0; r < N; r++) begin
                if (pend[r].size() < 4 && $urandom_range(0, 7) == 0)
                    add_burst(r, $urandom_range(1, 20));
            end
            step();
        end
        gap_pct  = 0;
        full_pct = 0;
        repeat (120) step();

        // Asynchronous reset in the middle of a burst.
        add_burst(3, 6);
        repeat (3) step();
        check("pre_rst_busy", 64'(busy), 64'(1));
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_async");
        for (int r = 0; r < N; r++) begin
            pend[r].delete();
            hold[r] = 1'b0;
        end
        model_reset();
        #1;
        rst = 1'b0;
        add_burst(3, 2);
        add_burst(0, 2);
        repeat (10) step();

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
